soc_decerr_slave: RTL
=====================

# soc_decerr_slave

AXI4 default (error) slave hung on the crossbar's default port behind the SoC address map. Any transaction whose address matches no rule (Debug, ROM, CLINT, PLIC, Cluster, AXILiteDom, APB_SLVS, L2SPM, Timer, SPI, Ethernet, UART, DMA_CFG, IOPMP_CFG, HYAXI) is routed here. The slave terminates the transaction protocol-correctly with DECERR and records the faulting access for software. It has one outstanding transaction per direction, and the read and write paths are independent.

## Interface
- ID_WIDTH, 8, AXI ID width on the crossbar master side (IdWidth + clog2(NrSlaves)).
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width.
- CNT_WIDTH, 16, width of the saturating error counter.
- clk_i  in  1  SoC clock.
- rst_ni  in  1  asynchronous active-low reset.
- aw_valid_i / aw_ready_o  in/out  1  AW handshake.
- aw_id_i  in  ID_WIDTH  write ID.
- aw_addr_i  in  ADDR_WIDTH  write address.
- w_valid_i / w_ready_o  in/out  1  W handshake; W data and strobe are ignored.
- w_last_i  in  1  last W beat.
- b_valid_o / b_ready_i  out/in  1  B handshake.
- b_id_o  out  ID_WIDTH  echoed AW ID.
- b_resp_o  out  2  always 2'b11 (DECERR).
- ar_valid_i / ar_ready_o  in/out  1  AR handshake.
- ar_id_i  in  ID_WIDTH  read ID.
- ar_addr_i  in  ADDR_WIDTH  read address.
- ar_len_i  in  8  burst length minus one.
- r_valid_o / r_ready_i  out/in  1  R handshake.
- r_id_o  out  ID_WIDTH  echoed AR ID.
- r_data_o  out  DATA_WIDTH  constant 64'hDEC0_DEE0_BADA_DD00, truncated to DATA_WIDTH.
- r_resp_o  out  2  always 2'b11.
- r_last_o  out  1  final beat.
- err_clr_i  in  1  single-cycle clear of the log.
- err_irq_o  out  1  level interrupt, high while err_cnt_o != 0.
- err_addr_o  out  ADDR_WIDTH  address of the first fault since the last clear.
- err_is_write_o  out  1  1 if the first fault was a write.
- err_cnt_o  out  CNT_WIDTH  saturating fault count.

## Operation
- Write FSM: W_IDLE → W_DRAIN → W_RESP.
  - W_IDLE: aw_ready_o=1. On the AW handshake, latch aw_id_i and go to W_DRAIN.
  - W_DRAIN: w_ready_o=1. Every W beat is consumed. A beat with w_last_i=1 moves the FSM to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o = latched ID. On b_ready_i, return to W_IDLE.
  - W beats presented while in W_IDLE are stalled (w_ready_o=0).
- Read FSM: R_IDLE → R_SEND.
  - R_IDLE: ar_ready_o=1. On the AR handshake, latch the ID and ar_len_i, and clear the 8-bit beat counter.
  - R_SEND: r_valid_o=1. r_last_o = (beat_cnt == latched len). Each handshake increments beat_cnt. The handshake with r_last_o=1 returns the FSM to R_IDLE.
  - ar_len_i=255 yields 256 beats; the counter never wraps before the last beat.
- Log, updated on the clock edge:
  - Events = AW handshake + AR handshake, so 0, 1 or 2 per cycle.
  - err_clr_i is applied first: count, address and flag are zeroed, then same-cycle events are applied.
  - Count increments by the number of events and saturates at all-ones.
  - If the count was 0 after the clear step, capture the faulting address and direction. When AW and AR handshake in the same cycle, the write wins the capture and the count increments by 2.
  - Address and flag hold until the next clear.
- Reset (any time, including mid-burst): both FSMs go to IDLE and all log registers go to 0. The in-flight transaction is dropped, so the crossbar must be reset together with this block.

## Timing
- Reset values:
  - 1 during reset: aw_ready_o, ar_ready_o.
  - 0 during reset: w_ready_o, b_valid_o, r_valid_o, r_last_o, err_irq_o, err_cnt_o, err_addr_o, err_is_write_o, b_id_o, r_id_o.
  - Constant regardless of reset: b_resp_o, r_resp_o, r_data_o.
- All handshake outputs decode from registered state only; there is no combinational path from valid to ready.
- Write latency:
  - AW accepted in cycle 0.
  - w_ready_o is high from cycle 1.
  - If WLAST is accepted in cycle n, b_valid_o is high from cycle n+1.
  - The next AW is accepted no earlier than the cycle after the B handshake.
- Read latency:
  - AR accepted in cycle 0.
  - The first R beat is valid in cycle 1.
  - With r_ready_i held high, one beat per cycle.
  - ar_ready_o returns the cycle after the last beat.
- Valid outputs stay stable until their handshake (AXI rule).
- err_irq_o and err_cnt_o reflect an event one cycle after the handshake.

## Configuration
- SOC_DECERR_LOG_EN defined: the error log and interrupt are implemented as described above.
- SOC_DECERR_LOG_EN undefined: the log registers are not instantiated. err_irq_o, err_cnt_o, err_addr_o and err_is_write_o are tied to 0, err_clr_i is ignored, and DECERR termination is unchanged.

## Test plan
- Write with AW addr 64'h6000_0000, ID 8'h15, 4 W beats, WLAST on beat 4 → B with ID 8'h15 and resp 2'b11 one cycle after WLAST; err_cnt_o=1, err_addr_o=64'h6000_0000, err_is_write_o=1.
- Read with AR addr 64'h6000_1000, ar_len_i=3, r_ready_i toggling every other cycle → exactly 4 beats, each with resp 2'b11 and the constant data; r_last_o only on beat 4; ar_ready_o low until the cycle after the last beat.
- AW and AR handshake in the same cycle after a clear → err_cnt_o=2, captured address is the AW address, err_is_write_o=1; a subsequent read does not change err_addr_o.
- err_clr_i asserted in the same cycle as an AR handshake to 64'h6800_0000 → err_cnt_o=1, err_addr_o=64'h6800_0000, err_irq_o stays high.
- Force the count to all-ones, then one more fault → count holds at all-ones.
- Assert rst_ni mid-burst at beat 2 of 8, then release → r_valid_o=0, ar_ready_o=1, log zeroed, and the next AR is served normally.

Source files
------------

// File: rtl/soc_decerr_slave.sv
// AXI4 default slave: terminates unmapped accesses with DECERR and logs the first fault.
// Define SOC_DECERR_LOG_EN to build the error log and interrupt; otherwise those outputs tie to 0.
module soc_decerr_slave #(
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // Write address / data / response
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic                  w_last_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    // Read address / data
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    // Error log
    input  logic                  err_clr_i,
    output logic                  err_irq_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  err_is_write_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    localparam logic [63:0] ErrData = 64'hDEC0_DEE0_BADA_DD00;

    typedef enum logic [1:0] {WIdle, WDrain, WResp} w_state_e;
    typedef enum logic {RIdle, RSend} r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;

    assign b_resp_o = 2'b11;
    assign r_resp_o = 2'b11;
    assign r_data_o = DATA_WIDTH'(ErrData);
    assign b_id_o   = b_id_q;
    assign r_id_o   = r_id_q;

    // Write path
    always_comb begin
        w_state_d  = w_state_q;
        b_id_d     = b_id_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) begin
                    b_id_d    = aw_id_i;
                    w_state_d = WDrain;
                end
            end
            WDrain: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) begin
                    w_state_d = WResp;
                end
            end
            WResp: begin
                b_valid_o = 1'b1;
                if (b_ready_i) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Read path
    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        len_d      = len_q;
        beat_d     = beat_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    r_id_d    = ar_id_i;
                    len_d     = ar_len_i;
                    beat_d    = 8'd0;
                    r_state_d = RSend;
                end
            end
            RSend: begin
                r_valid_o = 1'b1;
                r_last_o  = (beat_q == len_q);
                if (r_ready_i) begin
                    if (r_last_o) begin
                        r_state_d = RIdle;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            b_id_q    <= '0;
            r_id_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            b_id_q    <= b_id_d;
            r_id_q    <= r_id_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
        end
    end

`ifdef SOC_DECERR_LOG_EN
    logic                  aw_hs, ar_hs;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_base;
    logic [CNT_WIDTH:0]    cnt_sum;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    // Clear is applied before same-cycle events; the write wins a simultaneous capture.
    always_comb begin
        cnt_base = err_clr_i ? '0 : cnt_q;
        addr_d   = err_clr_i ? '0 : addr_q;
        wr_d     = err_clr_i ? 1'b0 : wr_q;
        cnt_sum  = {1'b0, cnt_base} + {{CNT_WIDTH{1'b0}}, aw_hs} + {{CNT_WIDTH{1'b0}}, ar_hs};
        cnt_d    = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        if ((aw_hs || ar_hs) && (cnt_base == '0)) begin
            addr_d = aw_hs ? aw_addr_i : ar_addr_i;
            wr_d   = aw_hs;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            wr_q   <= wr_d;
        end
    end

    assign err_cnt_o      = cnt_q;
    assign err_addr_o     = addr_q;
    assign err_is_write_o = wr_q;
    assign err_irq_o      = (cnt_q != '0);
`else
    logic unused_log;
    assign unused_log     = ^{err_clr_i, aw_addr_i, ar_addr_i};
    assign err_cnt_o      = '0;
    assign err_addr_o     = '0;
    assign err_is_write_o = 1'b0;
    assign err_irq_o      = 1'b0;
`endif

endmodule
